// File: rtl/write_buffer_if.sv
// -----------------------------------------------------------------------------
// write_buffer_if
//
// Bundle of every signal exchanged between the write buffer and its neighbours
// (the write-through data cache on one side, main data memory on the other).
//
//   slave  modport : used by write_buffer itself
//   master modport : used by whatever drives the buffer (cache + memory model)
//
// Signals:
//   wr_req, wr_addr, wr_data   cache -> buffer   store push
//   wb_full, wb_empty          buffer -> cache   occupancy flags
//   mem_wr_en, mem_addr,
//   mem_wdata                  buffer -> memory  head entry offered to memory
//   mem_ready                  memory -> buffer  memory accepts the head entry
//   fwd_addr                   cache -> buffer   load address to look up
//   fwd_hit, fwd_data          buffer -> cache   store-to-load forwarding result
// -----------------------------------------------------------------------------
interface write_buffer_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wb_full;
   logic              wb_empty;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic              mem_ready;
   logic [ADDR_W-1:0] fwd_addr;
   logic              fwd_hit;
   logic [WIDTH-1:0]  fwd_data;

   modport slave (
      input  wr_req, wr_addr, wr_data, mem_ready, fwd_addr,
      output wb_full, wb_empty, mem_wr_en, mem_addr, mem_wdata, fwd_hit, fwd_data
   );

   modport master (
      output wr_req, wr_addr, wr_data, mem_ready, fwd_addr,
      input  wb_full, wb_empty, mem_wr_en, mem_addr, mem_wdata, fwd_hit, fwd_data
   );

endinterface : write_buffer_if

// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
//
// Posted-write FIFO between the write-through data cache and slow main memory.
// Stores are pushed in a single cycle; entries drain strictly in order to
// memory over a valid/ready handshake (mem_wr_en / mem_ready).
//
// Parameters:
//   WIDTH   data word width
//   ADDR_W  word-address width
//   DEPTH   number of entries (power of two, >= 2)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-low reset; discards every pending write
//   bus     write_buffer_if.slave (push side, memory side, forwarding lookup)
//
// Build option:
//   WB_FORWARD_EN  when defined, loads can pick up data from pending entries
//                  (fwd_hit / fwd_data); when undefined both are tied to 0 and
//                  no compare logic exists.
// -----------------------------------------------------------------------------
module write_buffer #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   write_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
   } entry_t;

   entry_t            entry_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   occ_e              occ;
   logic              push;
   logic              pop;

   // ---------------------------------------------------------------------------
   // Occupancy is decoded from the registered count only, so the flags change
   // in the cycle after the edge that moved the count.
   // ---------------------------------------------------------------------------
   always_comb begin
      if (count_q == '0)
         occ = OCC_EMPTY;
      else if (count_q == CNT_W'(DEPTH))
         occ = OCC_FULL;
      else
         occ = OCC_PARTIAL;
   end

   // A push into a full buffer is refused even when a pop happens in the same
   // cycle: the pusher only sees the registered wb_full.
   assign push = bus.wr_req && (occ != OCC_FULL);
   assign pop  = (occ != OCC_EMPTY) && bus.mem_ready;

   // NOTE: next-state logic is purely combinational; every variable gets a
   // default at the top of the block so no latch can be inferred.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)
         head_d = head_q + PTR_W'(1);
      if (push)
         tail_d = tail_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: the entry array is reset on purpose: mem_addr / mem_wdata read the
   // head entry directly, and they must show 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            entry_q[i] <= '0;
      end else if (push) begin
         entry_q[tail_q] <= '{addr: bus.wr_addr, data: bus.wr_data};
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs toward cache and memory. mem_wr_en follows the count register,
   // so it drops asynchronously with reset.
   // ---------------------------------------------------------------------------
   assign bus.wb_full   = (occ == OCC_FULL);
   assign bus.wb_empty  = (occ == OCC_EMPTY);
   assign bus.mem_wr_en = (occ != OCC_EMPTY);
   assign bus.mem_addr  = entry_q[head_q].addr;
   assign bus.mem_wdata = entry_q[head_q].data;

   // ---------------------------------------------------------------------------
   // Store-to-load forwarding
   // ---------------------------------------------------------------------------
`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0] fwd_idx;
   logic             fwd_hit_c;
   logic [WIDTH-1:0] fwd_data_c;

   // Walk from oldest (head) to youngest; a later match overwrites an earlier
   // one, so the youngest matching store wins. Slot offset i is valid only
   // while i < count, which excludes stale slots and same-cycle pushes.
   always_comb begin
      fwd_idx    = '0;
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (entry_q[fwd_idx].addr == bus.fwd_addr)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = entry_q[fwd_idx].data;
         end
      end
   end

   assign bus.fwd_hit  = fwd_hit_c;
   assign bus.fwd_data = fwd_data_c;
`else
   // Without forwarding the cache stalls loads until wb_empty; the lookup
   // address is intentionally left unconnected.
   logic unused_fwd_addr;
   assign unused_fwd_addr = ^bus.fwd_addr;

   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = '0;
`endif

endmodule : write_buffer

// File: doc/write_buffer.md
# write_buffer

Posted-write FIFO between the write-through data cache and the slow main data memory. Every store the cache writes through is pushed here in one cycle, so the core stalls only when the buffer is full. Entries are drained in order to memory over a ready/valid handshake. A compile-time option lets loads forward data from pending entries.

## Interface
- `WIDTH`, 32, data word width
- `ADDR_W`, 10, word-address width (matches the cache's `alu_res[9:0]` address)
- `DEPTH`, 4, number of entries; power of two, ≥2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_req`  in  1  cache pushes a write this cycle
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  WIDTH  write data
- `wb_full`  out  1  buffer holds DEPTH entries; cache must stall, not push
- `wb_empty`  out  1  no pending entries
- `mem_wr_en`  out  1  head entry valid toward memory
- `mem_addr`  out  ADDR_W  head entry address
- `mem_wdata`  out  WIDTH  head entry data
- `mem_ready`  in  1  memory accepts the head entry this cycle
- `fwd_addr`  in  ADDR_W  load address to look up
- `fwd_hit`  out  1  a pending entry matches `fwd_addr`
- `fwd_data`  out  WIDTH  data of the youngest matching entry

## Operation
- Storage: DEPTH-entry circular array with head pointer, tail pointer and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Occupancy states, derived from count:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Push: accepted when `wr_req` and count<DEPTH. The entry is written at the tail and the tail advances.
  - `wr_req` while FULL is ignored: no entry, no state change. The pushing side is responsible for honouring `wb_full`.
- Pop: occurs when `mem_wr_en && mem_ready`; the head advances.
- Simultaneous push and pop: both occur and count is unchanged.
  - In FULL the push is still refused even if a pop happens the same cycle, because `wb_full` is registered state.
- Memory handshake:
  - `mem_wr_en` = !EMPTY.
  - `mem_addr` and `mem_wdata` come straight from the head entry and hold stable until the pop.
  - Memory may hold `mem_ready` low for any number of cycles.
  - `mem_ready` while EMPTY is ignored.
- Ordering: strictly FIFO. Repeated writes to the same address are neither merged nor reordered.
- Forwarding:
  - Combinational compare of `fwd_addr` against all valid entries.
  - `fwd_data` comes from the match closest to the tail (youngest).
  - Only stored entries are searched. A push in the same cycle is not visible until the next cycle.
- Reset, including mid-drain: all pending writes are discarded, pointers and count clear, and `mem_wr_en` drops immediately (asynchronously).

## Timing
- Values after reset:
  - `wb_empty`=1
  - `wb_full`=0, `mem_wr_en`=0, `fwd_hit`=0
  - `mem_addr`=0, `mem_wdata`=0, `fwd_data`=0
  - all entry storage cleared to 0
- Latency:
  - A push at edge N into EMPTY gives `mem_wr_en`=1 after edge N.
  - With `mem_ready` held high, the earliest pop is edge N+1.
- Throughput: one push and one pop per cycle.
- `wb_full` and `wb_empty` are functions of registered count only. They update in the cycle after the edge that changes count.
- `fwd_hit` and `fwd_data` are combinational from `fwd_addr` and registered state. They are valid within the same cycle as `fwd_addr`.

## Configuration
- `WB_FORWARD_EN` defined: forwarding compare logic is built as described above.
- `WB_FORWARD_EN` undefined:
  - `fwd_hit` and `fwd_data` are tied to 0 and no compare logic is built.
  - The cache must then stall loads until `wb_empty`.

## Test plan
- Reset, then 3 pushes (0x010/0xA, 0x011/0xB, 0x012/0xC) with `mem_ready`=1 → memory sees 0xA, 0xB, 0xC in order on consecutive cycles, then `wb_empty`=1.
- `mem_ready`=0, DEPTH=4 pushes → `wb_full`=1. A 5th push (0x3FF/0xDEAD) is dropped. After a full drain, exactly 4 writes are seen and none carries 0xDEAD.
- Full buffer, push and `mem_ready`=1 in the same cycle → pop occurs, push refused, count=3. Next cycle the push is accepted and count=4.
- Pushes 0x020/0x1 then 0x020/0x2, `mem_ready`=0, `fwd_addr`=0x020 → `fwd_hit`=1, `fwd_data`=0x2. `fwd_addr`=0x021 → `fwd_hit`=0. Without `WB_FORWARD_EN` → `fwd_hit`=0 in both cases.
- Wrap-around: 10 push/pop cycles with `mem_ready` toggling every cycle → all 10 writes delivered in order and the pointers wrap correctly.
- Reset asserted while 2 entries are pending and `mem_wr_en`=1 → `mem_wr_en`=0 immediately. After release, `wb_empty`=1 and no stale write is issued.
